// File: rtl/sort_sequencer.sv
// sort_sequencer: loads 25 words, sorts them in place with one odd-even
// transposition phase per cycle, then streams them out through a snake permutation.
module sort_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PASSES = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N    = 25;
    localparam int unsigned IDXW = 5;
    localparam int unsigned PHW  = (PASSES < 2) ? 1 : $clog2(PASSES);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);
    localparam logic [PHW-1:0]  LAST_PH   = PHW'(PASSES - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   wr_cnt;
    logic [IDXW-1:0]   rd_cnt;
    logic [PHW-1:0]    phase;
    logic [WIDTH-1:0]  mem      [N];
    logic [WIDTH-1:0]  mem_sort [N];

    // Fixed snake reordering applied on the read side.
    function automatic logic [IDXW-1:0] perm(input logic [IDXW-1:0] i);
        case (i)
            5'd5:    perm = 5'd9;
            5'd9:    perm = 5'd5;
            5'd6:    perm = 5'd8;
            5'd8:    perm = 5'd6;
            5'd15:   perm = 5'd19;
            5'd19:   perm = 5'd15;
            5'd16:   perm = 5'd18;
            5'd18:   perm = 5'd16;
            default: perm = i;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every handshake.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (in_valid && wr_cnt == LAST_IDX) state_nxt = S_SORT;
                S_SORT:  if (phase == LAST_PH) state_nxt = S_OUT;
                S_OUT:   if (out_ready && rd_cnt == LAST_IDX) state_nxt = S_LOAD;
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    // Output decode from registered state, counters and buffer.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD: in_ready = 1'b1;
            S_SORT: busy = 1'b1;
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = rd_cnt;
                out_data  = mem[perm(rd_cnt)];
                out_last  = (rd_cnt == LAST_IDX);
            end
            default: ;
        endcase
    end

    // One transposition phase: even phases pair (0,1).., odd phases pair (1,2)..
    always_comb begin
        mem_sort = mem;
        for (int j = 0; j < int'(N) - 1; j++) begin
            if (1'(j) == phase[0] && mem[j] > mem[j+1]) begin
                mem_sort[j]   = mem[j+1];
                mem_sort[j+1] = mem[j];
            end
        end
    end

    // Buffer, counters and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            phase  <= '0;
            done   <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (flush) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                phase  <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        phase  <= '0;
                        rd_cnt <= '0;
                        if (in_valid) begin
                            mem[wr_cnt] <= in_data;
                            wr_cnt      <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + 1'b1;
                        end
                    end
                    S_SORT: begin
                        mem    <= mem_sort;
                        rd_cnt <= '0;
                        phase  <= (phase == LAST_PH) ? '0 : phase + 1'b1;
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
                            done   <= (rd_cnt == LAST_IDX);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed-sequence bench with randomized data for sort_sequencer.
module tb_sort_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    logic [15:0] batch [25];
    logic [15:0] expv  [25];
    int perm_tab [25] = '{0, 1, 2, 3, 4, 9, 8, 7, 6, 5, 10, 11, 12, 13, 14,
                          19, 18, 17, 16, 15, 20, 21, 22, 23, 24};

    sort_sequencer #(.WIDTH(16), .PASSES(25)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sort the batch ascending, then read it through the snake order.
    task automatic build_expected();
        logic [15:0] s [25];
        logic [15:0] t;
        for (int i = 0; i < 25; i++) s[i] = batch[i];
        for (int i = 1; i < 25; i++) begin
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        end
        for (int k = 0; k < 25; k++) expv[k] = s[perm_tab[k]];
    endtask

    task automatic load_batch(input bit gaps);
        build_expected();
        for (int i = 0; i < 25; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            chk("in_ready_load", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = batch[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Wait out the sort, then consume the stream; optional stall or flush point.
    task automatic drain(input int stall_idx, input int flush_idx);
        int lat;
        lat = 0;
        busy_cnt = 0;
        chk("in_ready_sort", 32'(in_ready), 32'd0);
        while (out_valid !== 1'b1 && lat < 200) begin
            busy_cnt += int'(busy);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd25);
        out_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == flush_idx) begin
                chk("flush_idx", 32'(out_idx), 32'(k));
                flush = 1'b1;
                tick();
                flush = 1'b0;
                chk("flush_in_ready",  32'(in_ready),  32'd1);
                chk("flush_out_valid", 32'(out_valid), 32'd0);
                chk("flush_done",      32'(done),      32'd0);
                chk("flush_busy",      32'(busy),      32'd0);
                tick();
                chk("flush_done2",     32'(done),      32'd0);
                return;
            end
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_idx",   32'(out_idx),   32'(k));
            chk("out_data",  32'(out_data),  32'(expv[k]));
            chk("out_last",  32'(out_last),  32'(k == 24));
            chk("done_low",  32'(done),      32'd0);
            busy_cnt += int'(busy);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_idx",  32'(out_idx),  32'(k));
                    chk("stall_data", 32'(out_data), 32'(expv[k]));
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("done_pulse",   32'(done),      32'd1);
        chk("in_ready_end", 32'(in_ready),  32'd1);
        chk("out_valid_end",32'(out_valid), 32'd0);
        tick();
        chk("done_once",    32'(done),      32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_reset_outputs("idle");

        // Ascending input, back-to-back.
        for (int i = 0; i < 25; i++) batch[i] = 16'(i);
        load_batch(1'b0);
        drain(-1, -1);

        // Descending input: same output, busy for sort plus stream.
        for (int i = 0; i < 25; i++) batch[i] = 16'(24 - i);
        load_batch(1'b0);
        drain(-1, -1);
        chk("busy_cycles", 32'(busy_cnt), 32'd50);

        // Heavy duplicates of 0, 7 and FFFF.
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(2, 0))
                0:       batch[i] = 16'h0000;
                1:       batch[i] = 16'h0007;
                default: batch[i] = 16'hFFFF;
            endcase
        end
        load_batch(1'b0);
        drain(-1, -1);

        // Gapped input and a 3-cycle stall at index 5.
        for (int i = 0; i < 25; i++) batch[i] = 16'($urandom);
        load_batch(1'b1);
        drain(5, -1);

        // Reset in the middle of the sort.
        for (int i = 0; i < 25; i++) batch[i] = 16'($urandom);
        load_batch(1'b0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midsort_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) batch[i] = 16'($urandom_range(300, 0));
        load_batch(1'b0);
        drain(-1, -1);

        // Flush during output, then a clean batch.
        for (int i = 0; i < 25; i++) batch[i] = 16'($urandom);
        load_batch(1'b0);
        drain(-1, 12);
        for (int i = 0; i < 25; i++) batch[i] = 16'($urandom);
        load_batch(1'b0);
        drain(-1, -1);

        // Extra random batches.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 25; i++) batch[i] = 16'($urandom);
            load_batch(r[0]);
            drain(int'($urandom_range(24, 0)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
